// File: rtl/decade_pkg.sv
// ============================================================================
//  Module      : decade_pkg
//  Description : Shared types, 2-of-5 code constants and digit successor for
//                the decade ring-counter decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decade_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [4:0] code_t;

    // Ring-code patterns {a,b,c,d,e} for each decimal digit
    localparam code_t c_code_d0 = 5'b00011;
    localparam code_t c_code_d1 = 5'b10010;
    localparam code_t c_code_d2 = 5'b10001;
    localparam code_t c_code_d3 = 5'b01001;
    localparam code_t c_code_d4 = 5'b11000;
    localparam code_t c_code_d5 = 5'b10100;
    localparam code_t c_code_d6 = 5'b01100;
    localparam code_t c_code_d7 = 5'b01010;
    localparam code_t c_code_d8 = 5'b00110;
    localparam code_t c_code_d9 = 5'b00101;

    localparam digit_t c_digit_max = 4'd9;

    function automatic digit_t digit_succ(input digit_t d);
        digit_succ = (d == c_digit_max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage : decade_pkg

`default_nettype wire

// File: rtl/decade_code_lut.sv
// ============================================================================
//  Module      : decade_code_lut
//  Description : Combinational 2-of-5 ring code to binary digit decode with
//                legality flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decade_code_lut
    import decade_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [3:0] o_digit,
    output logic       o_legal
);

    // Every 2-hot pattern appears in the table, so a table miss means illegal
    always_comb begin
        o_digit = 4'd0;
        o_legal = 1'b1;
        case (i_code)
            c_code_d0: o_digit = 4'd0;
            c_code_d1: o_digit = 4'd1;
            c_code_d2: o_digit = 4'd2;
            c_code_d3: o_digit = 4'd3;
            c_code_d4: o_digit = 4'd4;
            c_code_d5: o_digit = 4'd5;
            c_code_d6: o_digit = 4'd6;
            c_code_d7: o_digit = 4'd7;
            c_code_d8: o_digit = 4'd8;
            c_code_d9: o_digit = 4'd9;
            default:   o_legal = 1'b0;
        endcase
    end

endmodule : decade_code_lut

`default_nettype wire

// File: rtl/decade_decode.sv
// ============================================================================
//  Module      : decade_decode
//  Description : Samples a 2-of-5 decade ring code, tracks the digit, flags
//                step/wrap and sticky code/sequence errors.
//                Optional saturating error counter: DECADE_DECODE_ERRCNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decade_decode
    import decade_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_sample,
    input  logic [4:0] i_code,
    input  logic       i_clear_err,
    output logic [3:0] o_digit,
    output logic       o_valid,
    output logic       o_step,
    output logic       o_wrap,
    output logic       o_code_err,
`ifdef DECADE_DECODE_ERRCNT_EN
    output logic [3:0] o_errcnt,
`endif
    output logic       o_seq_err
);

    digit_t w_dec;
    logic   w_legal;
    digit_t w_succ;
    logic   w_is_same;
    logic   w_is_succ;
    logic   w_code_hit;
    logic   w_seq_hit;

    digit_t r_digit;
    logic   r_valid;
    logic   r_step;
    logic   r_wrap;
    logic   r_code_err;
    logic   r_seq_err;

    decade_code_lut u_lut (
        .i_code  (i_code),
        .o_digit (w_dec),
        .o_legal (w_legal)
    );

    assign w_succ     = digit_succ(r_digit);
    assign w_is_same  = (w_dec == r_digit);
    assign w_is_succ  = (w_dec == w_succ);
    assign w_code_hit = i_sample && !w_legal;
    // Sequence check only applies once a reference digit is held
    assign w_seq_hit  = i_sample && w_legal && r_valid && !w_is_same && !w_is_succ;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_digit    <= 4'd0;
            r_valid    <= 1'b0;
            r_step     <= 1'b0;
            r_wrap     <= 1'b0;
            r_code_err <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            if (i_clear_err) begin
                r_code_err <= 1'b0;
                r_seq_err  <= 1'b0;
            end
            if (i_sample) begin
                if (!w_legal) begin
                    r_code_err <= 1'b1;
                    r_valid    <= 1'b0;
                end else if (!r_valid) begin
                    r_digit <= w_dec;
                    r_valid <= 1'b1;
                end else if (w_is_same) begin
                    r_digit <= r_digit;
                end else if (w_is_succ) begin
                    r_digit <= w_dec;
                    r_step  <= 1'b1;
                    r_wrap  <= (w_dec == 4'd0);
                end else begin
                    r_digit   <= w_dec;
                    r_seq_err <= 1'b1;
                end
            end
        end
    end

`ifdef DECADE_DECODE_ERRCNT_EN
    logic [3:0] r_errcnt;
    logic       w_err_hit;

    assign w_err_hit = w_code_hit || w_seq_hit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_errcnt <= 4'd0;
        end else if (i_clear_err) begin
            r_errcnt <= w_err_hit ? 4'd1 : 4'd0;
        end else if (w_err_hit && (r_errcnt != 4'd15)) begin
            r_errcnt <= r_errcnt + 4'd1;
        end
    end

    assign o_errcnt = r_errcnt;
`endif

    assign o_digit    = r_digit;
    assign o_valid    = r_valid;
    assign o_step     = r_step;
    assign o_wrap     = r_wrap;
    assign o_code_err = r_code_err;
    assign o_seq_err  = r_seq_err;

endmodule : decade_decode

`default_nettype wire

// File: tb/tb_decade_decode.sv
// ============================================================================
//  Module      : tb_decade_decode
//  Description : Directed self-checking bench for decade_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decade_decode;

    logic       clk;
    logic       reset_n;
    logic       sample;
    logic [4:0] code;
    logic       clear_err;
    logic [3:0] digit;
    logic       valid;
    logic       step;
    logic       wrap;
    logic       code_err;
    logic       seq_err;
`ifdef DECADE_DECODE_ERRCNT_EN
    logic [3:0] errcnt;
`endif

    int total = 0;
    int bad   = 0;

    decade_decode dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_sample    (sample),
        .i_code      (code),
        .i_clear_err (clear_err),
        .o_digit     (digit),
        .o_valid     (valid),
        .o_step      (step),
        .o_wrap      (wrap),
        .o_code_err  (code_err),
`ifdef DECADE_DECODE_ERRCNT_EN
        .o_errcnt    (errcnt),
`endif
        .o_seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one code for exactly one rising edge, return 1 time unit after it
    task automatic do_sample(input logic [4:0] c, input logic clr);
        @(negedge clk);
        sample    = 1'b1;
        code      = c;
        clear_err = clr;
        @(posedge clk);
        #1;
        sample    = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic do_idle(input logic clr);
        @(negedge clk);
        clear_err = clr;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({digit, valid, step, wrap, code_err, seq_err} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: got digit=%0d v=%b s=%b w=%b ce=%b se=%b want all 0",
                     digit, valid, step, wrap, code_err, seq_err);
        end
`ifdef DECADE_DECODE_ERRCNT_EN
        total++;
        if (errcnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_errcnt: got %0d want 0", errcnt);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ref_load;
        do_sample(5'b10010, 1'b0);
        total++;
        if ({valid, digit, step, wrap, code_err, seq_err} !== {1'b1, 4'd1, 4'b0000}) begin
            bad++;
            $display("FAIL ref_load: got v=%b d=%0d s=%b w=%b ce=%b se=%b want v=1 d=1 rest 0",
                     valid, digit, step, wrap, code_err, seq_err);
        end
    endtask

    task automatic test_count_sequence;
        logic [4:0] seq_codes [10];
        logic [3:0] exp_d;
        seq_codes = '{5'b10001, 5'b01001, 5'b11000, 5'b10100, 5'b01100,
                      5'b01010, 5'b00110, 5'b00101, 5'b00011, 5'b10010};
        for (int i = 0; i < 10; i++) begin
            exp_d = (i == 8) ? 4'd0 : ((i == 9) ? 4'd1 : 4'(i + 2));
            do_sample(seq_codes[i], 1'b0);
            total++;
            if (digit !== exp_d || step !== 1'b1 || wrap !== (i == 8) || valid !== 1'b1 || seq_err !== 1'b0) begin
                bad++;
                $display("FAIL count_step%0d: got d=%0d s=%b w=%b v=%b se=%b want d=%0d s=1 w=%b v=1 se=0",
                         i, digit, step, wrap, valid, seq_err, exp_d, (i == 8));
            end
        end
        do_idle(1'b0);
        total++;
        if (digit !== 4'd1 || step !== 1'b0 || wrap !== 1'b0 || valid !== 1'b1) begin
            bad++;
            $display("FAIL idle_hold: got d=%0d s=%b w=%b v=%b want d=1 s=0 w=0 v=1",
                     digit, step, wrap, valid);
        end
        do_sample(5'b10010, 1'b0);
        total++;
        if (digit !== 4'd1 || step !== 1'b0 || seq_err !== 1'b0 || code_err !== 1'b0) begin
            bad++;
            $display("FAIL same_digit: got d=%0d s=%b se=%b ce=%b want d=1 s=0 se=0 ce=0",
                     digit, step, seq_err, code_err);
        end
    endtask

    task automatic test_seq_err;
        do_sample(5'b10001, 1'b0);
        do_sample(5'b01001, 1'b0);
        do_sample(5'b11000, 1'b0);
        total++;
        if (digit !== 4'd4) begin
            bad++;
            $display("FAIL seq_setup: got d=%0d want 4", digit);
        end
        do_sample(5'b01100, 1'b0);
        total++;
        if (seq_err !== 1'b1 || digit !== 4'd6 || valid !== 1'b1 || step !== 1'b0 || code_err !== 1'b0) begin
            bad++;
            $display("FAIL seq_err: got se=%b d=%0d v=%b s=%b ce=%b want se=1 d=6 v=1 s=0 ce=0",
                     seq_err, digit, valid, step, code_err);
        end
`ifdef DECADE_DECODE_ERRCNT_EN
        total++;
        if (errcnt !== 4'd1) begin
            bad++;
            $display("FAIL seq_errcnt: got %0d want 1", errcnt);
        end
`endif
        do_idle(1'b1);
        total++;
        if (seq_err !== 1'b0 || code_err !== 1'b0 || digit !== 4'd6 || valid !== 1'b1) begin
            bad++;
            $display("FAIL clear_only: got se=%b ce=%b d=%0d v=%b want se=0 ce=0 d=6 v=1",
                     seq_err, code_err, digit, valid);
        end
`ifdef DECADE_DECODE_ERRCNT_EN
        total++;
        if (errcnt !== 4'd0) begin
            bad++;
            $display("FAIL clear_errcnt: got %0d want 0", errcnt);
        end
`endif
    endtask

    task automatic test_code_err;
        do_sample(5'b11100, 1'b0);
        total++;
        if (code_err !== 1'b1 || valid !== 1'b0 || digit !== 4'd6 || step !== 1'b0) begin
            bad++;
            $display("FAIL code_err: got ce=%b v=%b d=%0d s=%b want ce=1 v=0 d=6 s=0",
                     code_err, valid, digit, step);
        end
        do_sample(5'b00110, 1'b0);
        total++;
        if (digit !== 4'd8 || valid !== 1'b1 || seq_err !== 1'b0 || step !== 1'b0) begin
            bad++;
            $display("FAIL reload_after_err: got d=%0d v=%b se=%b s=%b want d=8 v=1 se=0 s=0",
                     digit, valid, seq_err, step);
        end
    endtask

    task automatic test_clear_err;
        do_sample(5'b10010, 1'b0);
        total++;
        if (seq_err !== 1'b1 || digit !== 4'd1) begin
            bad++;
            $display("FAIL pre_clear_seq: got se=%b d=%0d want se=1 d=1", seq_err, digit);
        end
        do_sample(5'b00000, 1'b1);
        total++;
        if (code_err !== 1'b1 || seq_err !== 1'b0 || valid !== 1'b0 || digit !== 4'd1) begin
            bad++;
            $display("FAIL clear_with_err: got ce=%b se=%b v=%b d=%0d want ce=1 se=0 v=0 d=1",
                     code_err, seq_err, valid, digit);
        end
`ifdef DECADE_DECODE_ERRCNT_EN
        total++;
        if (errcnt !== 4'd1) begin
            bad++;
            $display("FAIL clear_with_err_cnt: got %0d want 1", errcnt);
        end
        for (int i = 0; i < 13; i++) do_sample(5'b11111, 1'b0);
        total++;
        if (errcnt !== 4'd14) begin
            bad++;
            $display("FAIL errcnt_14: got %0d want 14", errcnt);
        end
        for (int i = 0; i < 4; i++) do_sample(5'b00001, 1'b0);
        total++;
        if (errcnt !== 4'd15) begin
            bad++;
            $display("FAIL errcnt_sat: got %0d want 15", errcnt);
        end
`else
        for (int i = 0; i < 17; i++) do_sample(5'b11111, 1'b0);
        total++;
        if (code_err !== 1'b1 || valid !== 1'b0 || digit !== 4'd1) begin
            bad++;
            $display("FAIL many_illegal: got ce=%b v=%b d=%0d want ce=1 v=0 d=1",
                     code_err, valid, digit);
        end
`endif
    endtask

    task automatic test_async_reset;
        do_idle(1'b1);
        do_sample(5'b00011, 1'b0);
        do_sample(5'b10010, 1'b0);
        total++;
        if (digit !== 4'd1 || valid !== 1'b1 || step !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: got d=%0d v=%b s=%b want d=1 v=1 s=1", digit, valid, step);
        end
        @(negedge clk);
        sample = 1'b1;
        code   = 5'b10001;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({digit, valid, step, wrap, code_err, seq_err} !== 9'd0) begin
            bad++;
            $display("FAIL async_reset: got d=%0d v=%b s=%b w=%b ce=%b se=%b want all 0",
                     digit, valid, step, wrap, code_err, seq_err);
        end
        @(posedge clk);
        sample = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_sample(5'b00011, 1'b0);
        total++;
        if (digit !== 4'd0 || valid !== 1'b1 || step !== 1'b0 || wrap !== 1'b0 || seq_err !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_load: got d=%0d v=%b s=%b w=%b se=%b want d=0 v=1 s=0 w=0 se=0",
                     digit, valid, step, wrap, seq_err);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        sample    = 1'b0;
        code      = 5'b00000;
        clear_err = 1'b0;
        test_reset();
        test_ref_load();
        test_count_sequence();
        test_seq_err();
        test_code_err();
        test_clear_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_decade_decode

`default_nettype wire

// File: doc/decade_decode.md
DECADE_DECODE -- requirements
Module: decade_decode

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_reset_n  input  1  asynchronous active-low reset.
REQ-004 i_sample  input  1  strobe; i_code is captured on an i_clk edge where i_sample=1.
REQ-005 i_code  input  5  2-of-5 ring code {a,b,c,d,e}, driven by a decade ring counter.
REQ-006 i_clear_err  input  1  clears sticky error flags and the error count.
REQ-007 o_digit  output  4  decoded digit 0-9, binary.
REQ-008 o_valid  output  1  o_digit reflects a legal code captured at the last sample.
REQ-009 o_step  output  1  one-cycle pulse on a legal +1 advance.
REQ-010 o_wrap  output  1  one-cycle pulse on the 9->0 advance; coincides with o_step.
REQ-011 o_code_err  output  1  sticky flag; a non-2-hot code was sampled.
REQ-012 o_seq_err  output  1  sticky flag; a legal code was sampled that is neither the held digit nor its successor.
REQ-013 o_errcnt  output  4  saturating error count; present only with DECADE_DECODE_ERRCNT_EN (REQ-030).

Function
REQ-014 Code table {a,b,c,d,e}, which SHALL be used exactly:
  10010=1, 10001=2, 01001=3, 11000=4, 10100=5, 01100=6, 01010=7, 00110=8, 00101=9, 00011=0.
REQ-015 A code SHALL be legal iff exactly two bits are set; all ten 2-hot patterns are in the table.
REQ-016 Successor order SHALL be 1->2->...->9->0->1.
REQ-017 Latency: all outputs SHALL reflect a sample on the first i_clk edge after capture (registered, 1 cycle).
REQ-018 Cycles with i_sample=0: o_digit, o_valid and the flags SHALL hold; o_step and o_wrap SHALL be 0.
REQ-019 Sample legal, o_valid=0 (reference load): o_digit<=decode, o_valid<=1, no step pulse, no sequence check.
REQ-020 Sample legal, same as o_digit: hold; no pulse; no error.
REQ-021 Sample legal, equal to the successor of o_digit: update o_digit; o_step=1; o_wrap=1 iff the new digit is 0.
REQ-022 Sample legal, any other digit: o_seq_err<=1; o_digit<=decode (resynchronise); o_valid stays 1; no pulse.
REQ-023 Sample illegal: o_code_err<=1; o_valid<=0; o_digit holds; no pulse. The next legal sample is handled by REQ-019.
REQ-024 i_clear_err=1 SHALL clear o_code_err, o_seq_err and o_errcnt on the next edge. If an error is detected on the same edge, the flag for that error SHALL be 1 and o_errcnt SHALL be 1.
REQ-025 i_clear_err SHALL NOT affect o_digit or o_valid.

Reset
REQ-026 When i_reset_n=0, the block SHALL asynchronously force o_digit=0, o_valid=0, o_step=0, o_wrap=0, o_code_err=0, o_seq_err=0, o_errcnt=0.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight sample.
REQ-028 The first legal sample after reset release SHALL follow REQ-019.

Configuration
REQ-029 The macro DECADE_DECODE_ERRCNT_EN SHALL be the only configuration option.
REQ-030 With the macro defined:
  o_errcnt exists.
  It increments by 1 on each sample that sets either error condition.
  It saturates at 15.
REQ-031 Without the macro, the o_errcnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package decade_pkg SHALL hold:
  the ten code constants;
  the digit typedef (4 bits);
  the code typedef (5 bits);
  a successor function.
REQ-033 The 2-of-5-to-digit decode, including the legal flag, SHALL be a combinational sub-module named decade_code_lut; all state SHALL live in decade_decode.

Verification
REQ-034 Reset then sample 10010 -> o_valid=1, o_digit=1, o_step=0, no flags.
REQ-035 From 1, sample 10001,01001,...,00011,10010 -> o_digit 2..9,0,1; o_step pulse each time; o_wrap only on 00101->00011.
REQ-036 Held at 4 (11000), sample 01100 -> o_seq_err=1, o_digit=6, o_valid=1, o_step=0.
REQ-037 Sample 11100 -> o_code_err=1, o_valid=0, o_digit held. Then sample 00110 -> o_digit=8, o_valid=1, no o_seq_err.
REQ-038 Assert i_clear_err on the same edge as a sample of 00000 -> o_code_err remains 1. With the macro, o_errcnt=1. 16+ further illegal samples -> o_errcnt=15.
REQ-039 Assert i_reset_n=0 between i_clk edges mid-sequence -> all outputs 0 immediately. After release, sample 00011 -> o_digit=0, o_valid=1, o_step=0.
